// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the SRAM front-end controller.
package sram_controller_pkg;

    // Controller sequencing states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WSETUP = 3'd1,
        ST_WPULSE = 3'd2,
        ST_WHOLD  = 3'd3,
        ST_RWAIT  = 3'd4,
        ST_RRESP  = 3'd5
    } state_e;

    localparam int DEFAULT_ADDRESS_SIZE = 18;
    localparam int DEFAULT_WORD_SIZE    = 8;

    // Width of the wait-state down-counter: enough for the longer of the two pulses
    function automatic int wait_width(input int write_cycles, input int read_cycles);
        int longest;
        longest = (write_cycles > read_cycles) ? write_cycles : read_cycles;
        return $clog2(longest) + 1;
    endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Request/response bus between the system side (master) and the SRAM controller (slave).
interface sram_controller_if #(
    parameter int ADDRESS_SIZE = sram_controller_pkg::DEFAULT_ADDRESS_SIZE,
    parameter int WORD_SIZE    = sram_controller_pkg::DEFAULT_WORD_SIZE
) ();
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_write;
    logic [ADDRESS_SIZE-1:0] req_address;
    logic [WORD_SIZE-1:0]    req_wdata;
    logic                    rsp_valid;
    logic [WORD_SIZE-1:0]    rsp_data;

    modport master (
        output req_valid, req_write, req_address, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/sram_wait_counter.sv
// Loadable down-counter used to time the SRAM write pulse and read access.
// Holds at zero once expired; done is high whenever the count is zero.
module sram_wait_counter #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: reload on state entry, otherwise count down and stick at zero
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);
endmodule

// File: rtl/sram_controller.sv
// Synchronous front-end for an asynchronous SRAM macro: one request at a time,
// bCE/bWE sequenced with programmable wait states, address/data frozen while bWE is low.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int ADDRESS_SIZE = DEFAULT_ADDRESS_SIZE,
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int WRITE_CYCLES = 2,
    parameter int READ_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    sram_controller_if.slave        bus,
    output logic [ADDRESS_SIZE-1:0] sram_address,
    output logic [WORD_SIZE-1:0]    sram_in_data,
    input  logic [WORD_SIZE-1:0]    sram_out_data,
    output logic                    b_ce,
    output logic                    b_we
);
    localparam int WAIT_W = wait_width(WRITE_CYCLES, READ_CYCLES);

    state_e                  state_q, state_d;
    logic [ADDRESS_SIZE-1:0] sram_address_q, sram_address_d;
    logic [WORD_SIZE-1:0]    sram_in_data_q, sram_in_data_d;
    logic [WORD_SIZE-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    req_ready_q, req_ready_d;
    logic                    b_ce_q, b_ce_d;
    logic                    b_we_q, b_we_d;
    logic                    cnt_load;
    logic [WAIT_W-1:0]       cnt_value;
    logic                    cnt_done;

    sram_wait_counter #(.WIDTH(WAIT_W)) u_wait (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (cnt_value),
        .done       (cnt_done)
    );

    // Next state, request latches and output values (outputs derived from the next state)
    always_comb begin
        state_d        = state_q;
        sram_address_d = sram_address_q;
        sram_in_data_d = sram_in_data_q;
        rsp_data_d     = rsp_data_q;
        rsp_valid_d    = 1'b0;
        cnt_load       = 1'b0;
        cnt_value      = '0;
        case (state_q)
            ST_IDLE: begin
                // Ready is only advertised from the registered flag, so the reset cycle accepts nothing
                if (bus.req_valid && req_ready_q) begin
                    sram_address_d = bus.req_address;
                    sram_in_data_d = bus.req_wdata;
                    if (bus.req_write) begin
                        state_d = ST_WSETUP;
                    end else begin
                        state_d   = ST_RWAIT;
                        cnt_load  = 1'b1;
                        cnt_value = WAIT_W'(READ_CYCLES - 1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WSETUP: begin
                state_d   = ST_WPULSE;
                cnt_load  = 1'b1;
                cnt_value = WAIT_W'(WRITE_CYCLES - 1);
            end
            ST_WPULSE: begin
                if (cnt_done) begin
                    state_d = ST_WHOLD;
                end else begin
                    state_d = ST_WPULSE;
                end
            end
            ST_WHOLD: begin
                state_d = ST_IDLE;
            end
            ST_RWAIT: begin
                // Last access cycle: capture the SRAM output and raise the response pulse
                if (cnt_done) begin
                    rsp_data_d  = sram_out_data;
                    rsp_valid_d = 1'b1;
                    state_d     = ST_RRESP;
                end else begin
                    state_d = ST_RWAIT;
                end
            end
            ST_RRESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        b_ce_d      = !(state_d inside {ST_WSETUP, ST_WPULSE, ST_WHOLD, ST_RWAIT});
        b_we_d      = (state_d != ST_WPULSE);
        req_ready_d = (state_d == ST_IDLE);
    end

    // State and registered outputs; reset forces the SRAM strobes inactive immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            sram_address_q <= '0;
            sram_in_data_q <= '0;
            rsp_data_q     <= '0;
            rsp_valid_q    <= 1'b0;
            req_ready_q    <= 1'b0;
            b_ce_q         <= 1'b1;
            b_we_q         <= 1'b1;
        end else begin
            state_q        <= state_d;
            sram_address_q <= sram_address_d;
            sram_in_data_q <= sram_in_data_d;
            rsp_data_q     <= rsp_data_d;
            rsp_valid_q    <= rsp_valid_d;
            req_ready_q    <= req_ready_d;
            b_ce_q         <= b_ce_d;
            b_we_q         <= b_we_d;
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign sram_address  = sram_address_q;
    assign sram_in_data  = sram_in_data_q;
    assign b_ce          = b_ce_q;
    assign b_we          = b_we_q;
endmodule
